// File: rtl/serial_if_pkg.sv
// serial_if_pkg: shared state encoding and default width for the bit-serial add interface
package serial_if_pkg;
    localparam int DEF_W = 8;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
endpackage

// File: rtl/bit_collector.sv
// bit_collector: serial-to-parallel capture register with write index and clear
module bit_collector
    import serial_if_pkg::*;
#(
    parameter int W = DEF_W,
    localparam int LW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         vld,
    input  logic         bit_in,
    output logic [W-1:0] data
);
    logic [W-1:0] data_q, data_d;
    logic [LW-1:0] idx_q, idx_d;
    always_comb begin
        data_d = data_q;
        idx_d = idx_q;
        if (clr) begin
            data_d = '0;
            idx_d = '0;
        end else if (vld) begin
            data_d[idx_q] = bit_in;
            idx_d = idx_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q <= '0;
        end else begin
            data_q <= data_d;
            idx_q <= idx_d;
        end
    end
    assign data = data_q;
endmodule

// File: rtl/serial_operand_driver.sv
// serial_operand_driver: streams two operands LSB-first to a bit-serial adder and collects the sum
module serial_operand_driver
    import serial_if_pkg::*;
#(
    parameter int W = DEF_W,
    localparam int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [LW-1:0] in_len,
    input  logic          gap,
    output logic          ser_vld,
    output logic          ser_a,
    output logic          ser_b,
    output logic          ser_last,
    input  logic          sum_in,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_sum
);
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, src_a, src_b;
    logic [LW-1:0] len_q, len_d, idx_q, idx_d, src_idx, src_len;
    logic ser_vld_q, ser_vld_d, ser_a_q, ser_a_d, ser_b_q, ser_b_d, ser_last_q, ser_last_d;
    logic cap_vld_q, cap_vld_d;
    logic accept, issue;
    // The accept cycle issues beat 0 straight from the inputs so the first beat lands one cycle later.
    always_comb begin
        accept = state_q == IDLE && in_vld;
        issue = (accept || (state_q == SEND && !ser_last_q)) && !gap;
        src_a = accept ? in_a : a_q;
        src_b = accept ? in_b : b_q;
        src_idx = accept ? '0 : idx_q;
        src_len = accept ? in_len : len_q;
        a_d = issue ? src_a >> 1 : src_a;
        b_d = issue ? src_b >> 1 : src_b;
        len_d = src_len;
        idx_d = issue ? src_idx + 1'b1 : src_idx;
        ser_vld_d = issue;
        ser_a_d = issue && src_a[0];
        ser_b_d = issue && src_b[0];
        ser_last_d = issue && src_idx == src_len;
        cap_vld_d = ser_vld_q;
        state_d = state_q;
        case (state_q)
            IDLE: state_d = accept ? SEND : IDLE;
            SEND: state_d = ser_last_q ? WAIT : SEND;
            WAIT: state_d = DONE;
            DONE: state_d = out_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            ser_vld_q <= 1'b0;
            ser_a_q <= 1'b0;
            ser_b_q <= 1'b0;
            ser_last_q <= 1'b0;
            cap_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            len_q <= len_d;
            idx_q <= idx_d;
            ser_vld_q <= ser_vld_d;
            ser_a_q <= ser_a_d;
            ser_b_q <= ser_b_d;
            ser_last_q <= ser_last_d;
            cap_vld_q <= cap_vld_d;
        end
    end
    bit_collector #(.W(W)) u_collector (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .vld(cap_vld_q),
        .bit_in(sum_in),
        .data(out_sum)
    );
    assign in_rdy = state_q == IDLE;
    assign out_vld = state_q == DONE;
    assign ser_vld = ser_vld_q;
    assign ser_a = ser_a_q;
    assign ser_b = ser_b_q;
    assign ser_last = ser_last_q;
endmodule

// File: tb/tb_serial_operand_driver.sv
// tb_serial_operand_driver: directed scoreboard bench with a reference serial adder in the loop
module tb_serial_operand_driver;
    localparam int W = 8;
    localparam int LW = $clog2(W);
    logic clk = 1'b0, rst = 1'b1, in_vld = 1'b0, gap = 1'b0, out_rdy = 1'b0;
    logic sum_in, carry;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [LW-1:0] in_len = '0;
    logic in_rdy, ser_vld, ser_a, ser_b, ser_last, out_vld;
    logic [W-1:0] out_sum;
    int passed = 0, total = 0;
    logic [2:0] beat_q[$];
    logic [W-1:0] sum_q[$];

    always #5 clk = ~clk;

    serial_operand_driver #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
        .in_len(in_len), .gap(gap), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
        .ser_last(ser_last), .sum_in(sum_in), .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum)
    );

    always @(posedge clk) begin
        if (rst) begin
            sum_in <= 1'b0;
            carry <= 1'b0;
        end else if (ser_vld) begin
            sum_in <= ser_a ^ ser_b ^ carry;
            carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry & (ser_a ^ ser_b)));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ser_vld) begin
                if (beat_q.size() == 0) chk("beat_extra", 32'(ser_vld), 32'd0);
                else chk("beat", 32'({ser_a, ser_b, ser_last}), 32'(beat_q.pop_front()));
            end else chk("last_without_vld", 32'(ser_last), 32'd0);
            if (out_vld && out_rdy) begin
                if (sum_q.size() == 0) chk("sum_extra", 32'(out_vld), 32'd0);
                else chk("sum", 32'(out_sum), 32'(sum_q.pop_front()));
            end
        end
    end

    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input int len,
                            input logic [31:0] gm, input int hold, input bit pend);
        int k, t, issued;
        logic [W-1:0] es;
        es = W'((int'(a) + int'(b)) & ((1 << (len + 1)) - 1));
        issued = 0;
        t = 0;
        for (int c = 0; c < 32; c++)
            if (issued <= len && !gm[c]) begin
                issued++;
                t = c;
            end
        chk("in_rdy_before", 32'(in_rdy), 32'd1);
        for (int i = 0; i <= len; i++) beat_q.push_back({a[i], b[i], i == len});
        sum_q.push_back(es);
        in_a = a;
        in_b = b;
        in_len = LW'(len);
        in_vld = 1'b1;
        gap = gm[0];
        step();
        in_vld = 1'b0;
        k = 1;
        while (!out_vld && k < 60) begin
            gap = gm[k];
            step();
            k++;
        end
        gap = 1'b0;
        chk("out_vld_latency", 32'(k), 32'(t + 3));
        for (int h = 0; h < hold; h++) begin
            if (pend) begin
                in_vld = 1'b1;
                in_a = 8'hEE;
                in_b = 8'h11;
                in_len = LW'(W - 1);
            end
            chk("hold_vld", 32'(out_vld), 32'd1);
            chk("hold_in_rdy", 32'(in_rdy), 32'd0);
            chk("hold_sum", 32'(out_sum), 32'(es));
            step();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("in_rdy_after", 32'(in_rdy), 32'd1);
        chk("out_vld_after", 32'(out_vld), 32'd0);
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_ser", 32'({ser_vld, ser_a, ser_b, ser_last}), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        run_word(8'h35, 8'h4A, 7, 32'h0, 0, 1'b0);
        run_word(8'hFF, 8'h01, 7, 32'h0, 0, 1'b0);
        run_word(8'h0F, 8'h01, 3, 32'h0, 0, 1'b0);
        run_word(8'hA5, 8'h5A, 7, 32'h0212, 0, 1'b0);
        run_word(8'h01, 8'h01, 0, 32'h0, 0, 1'b0);
        run_word(8'h01, 8'h00, 0, 32'h0, 0, 1'b0);
        run_word(8'h12, 8'h34, 7, 32'h0, 5, 1'b1);
        run_word(8'h80, 8'h80, 7, 32'h0, 0, 1'b0);
        run_word(8'h02, 8'h03, 1, 32'h1, 0, 1'b0);
        for (int i = 0; i <= 7; i++) beat_q.push_back({1'b1, 1'b1, i == 7});
        in_a = 8'hFF;
        in_b = 8'hFF;
        in_len = 3'd7;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        step();
        rst = 1'b1;
        beat_q.delete();
        sum_q.delete();
        step();
        rst = 1'b0;
        chk("midrst_ser_vld", 32'(ser_vld), 32'd0);
        chk("midrst_out_vld", 32'(out_vld), 32'd0);
        chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
        chk("midrst_out_sum", 32'(out_sum), 32'd0);
        run_word(8'h03, 8'h04, 3, 32'h0, 0, 1'b0);
        step();
        chk("beats_drained", 32'(beat_q.size()), 32'd0);
        chk("sums_drained", 32'(sum_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
